// File: rtl/piso_serializer_pkg.sv
// Shared constants for the parallel-in/serial-out serializer: the accepted
// strings for the shift-order parameter and the minimum legal word width.
package piso_serializer_pkg;

    localparam string ORDER_TRUE     = "TRUE";
    localparam string ORDER_FALSE    = "FALSE";
    localparam int    MIN_DATA_WIDTH = 2;

    // A word must contain at least two bits for the shift slices to exist.
    function automatic bit data_width_ok(input int width);
        return width >= MIN_DATA_WIDTH;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register. A word is loaded on a strobe and
// then shifted out one bit per enabled clock, LSB first or MSB first.
// Vacated positions fill with zero, so the output idles low once a word has
// been fully sent. A load on any enabled cycle aborts the word in progress.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int    DATA_WIDTH   = 8,
    parameter string DO_MSB_FIRST = ORDER_FALSE
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic                  enable_i,
    input  logic                  wr_enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  data_o
);

    // Any value other than "TRUE" selects LSB-first ordering.
    localparam bit MSB_FIRST = (DO_MSB_FIRST == ORDER_TRUE);

    logic [DATA_WIDTH-1:0] shreg;

    if (!data_width_ok(DATA_WIDTH)) begin : g_width_check
        $error("piso_serializer: DATA_WIDTH must be at least 2");
    end

    if (MSB_FIRST) begin : g_msb_first
        // Reset clears, enable gates everything, load beats shift; bits leave from the top.
        always_ff @(posedge clk_i) begin
            if (s_rst_i) begin
                shreg <= '0;
            end else if (enable_i) begin
                if (wr_enable_i) begin
                    shreg <= data_i;
                end else begin
                    shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end

        assign data_o = shreg[DATA_WIDTH-1];
    end else begin : g_lsb_first
        // Reset clears, enable gates everything, load beats shift; bits leave from the bottom.
        always_ff @(posedge clk_i) begin
            if (s_rst_i) begin
                shreg <= '0;
            end else if (enable_i) begin
                if (wr_enable_i) begin
                    shreg <= data_i;
                end else begin
                    shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
                end
            end
        end

        assign data_o = shreg[0];
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: four instances (LSB/MSB first,
// 8 and 16 bits) share the control inputs and are compared bit by bit with
// a word-level model of the expected serial ordering.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        s_rst;
    logic        enable;
    logic        wr_enable;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        out_l8, out_m8, out_l16, out_m16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_WIDTH(8), .DO_MSB_FIRST("FALSE")) dut_l8 (
        .clk_i(clk), .s_rst_i(s_rst), .enable_i(enable),
        .wr_enable_i(wr_enable), .data_i(data8), .data_o(out_l8));

    piso_serializer #(.DATA_WIDTH(8), .DO_MSB_FIRST("TRUE")) dut_m8 (
        .clk_i(clk), .s_rst_i(s_rst), .enable_i(enable),
        .wr_enable_i(wr_enable), .data_i(data8), .data_o(out_m8));

    piso_serializer #(.DATA_WIDTH(16), .DO_MSB_FIRST("FALSE")) dut_l16 (
        .clk_i(clk), .s_rst_i(s_rst), .enable_i(enable),
        .wr_enable_i(wr_enable), .data_i(data16), .data_o(out_l16));

    piso_serializer #(.DATA_WIDTH(16), .DO_MSB_FIRST("TRUE")) dut_m16 (
        .clk_i(clk), .s_rst_i(s_rst), .enable_i(enable),
        .wr_enable_i(wr_enable), .data_i(data16), .data_o(out_m16));

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; enable = 1'b1; wr_enable = 1'b1;
        data8 = 8'hFF; data16 = 16'hFFFF;
        repeat (2) tick();
        n_checks += 4;
        if (out_l8 !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_l8 got %b want 0", out_l8); end
        if (out_m8 !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_m8 got %b want 0", out_m8); end
        if (out_l16 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_l16 got %b want 0", out_l16); end
        if (out_m16 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m16 got %b want 0", out_m16); end
        s_rst = 1'b0; wr_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks += 2;
            if (out_l8 !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_l8[%0d] got %b want 0", i, out_l8); end
            if (out_m8 !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_m8[%0d] got %b want 0", i, out_m8); end
        end
    endtask

    task automatic test_fixed_word();
        bit lsb_exp[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
        bit msb_exp[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        bit el, em;
        enable = 1'b1; wr_enable = 1'b1; data8 = 8'hB2; data16 = 16'h0000;
        tick();
        wr_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            el = (k < 8) ? lsb_exp[k] : 1'b0;
            em = (k < 8) ? msb_exp[k] : 1'b0;
            n_checks += 2;
            if (out_l8 !== el) begin n_fail++; $display("[TB] FAIL fixed_l8 bit %0d got %b want %b", k, out_l8, el); end
            if (out_m8 !== em) begin n_fail++; $display("[TB] FAIL fixed_m8 bit %0d got %b want %b", k, out_m8, em); end
            tick();
        end
    endtask

    task automatic test_enable_stall();
        bit lsb_exp[12] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0};
        bit msb_exp[12] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
        enable = 1'b1; wr_enable = 1'b1; data8 = 8'hB2;
        tick();
        wr_enable = 1'b0;
        for (int j = 0; j < 12; j++) begin
            n_checks += 2;
            if (out_l8 !== lsb_exp[j]) begin n_fail++; $display("[TB] FAIL stall_l8 step %0d got %b want %b", j, out_l8, lsb_exp[j]); end
            if (out_m8 !== msb_exp[j]) begin n_fail++; $display("[TB] FAIL stall_m8 step %0d got %b want %b", j, out_m8, msb_exp[j]); end
            enable = !(j >= 1 && j <= 3);
            tick();
        end
        enable = 1'b1;
    endtask

    task automatic test_reload_reset();
        enable = 1'b1; wr_enable = 1'b1; data8 = 8'hFF; data16 = 16'hFFFF;
        tick();
        wr_enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_checks += 2;
            if (out_l8 !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_pre_l8 %0d got %b want 1", j, out_l8); end
            if (out_m8 !== 1'b1) begin n_fail++; $display("[TB] FAIL reload_pre_m8 %0d got %b want 1", j, out_m8); end
            if (j < 2) tick();
        end
        wr_enable = 1'b1; data8 = 8'h00; data16 = 16'h0000;
        tick();
        wr_enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks += 2;
            if (out_l8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reload_l8 %0d got %b want 0", j, out_l8); end
            if (out_m8 !== 1'b0) begin n_fail++; $display("[TB] FAIL reload_m8 %0d got %b want 0", j, out_m8); end
            tick();
        end
        wr_enable = 1'b1; data8 = 8'hFF; data16 = 16'hFFFF;
        tick();
        wr_enable = 1'b0;
        tick();
        n_checks += 4;
        if (out_l8 !== 1'b1)  begin n_fail++; $display("[TB] FAIL prerst_l8 got %b want 1", out_l8); end
        if (out_m8 !== 1'b1)  begin n_fail++; $display("[TB] FAIL prerst_m8 got %b want 1", out_m8); end
        if (out_l16 !== 1'b1) begin n_fail++; $display("[TB] FAIL prerst_l16 got %b want 1", out_l16); end
        if (out_m16 !== 1'b1) begin n_fail++; $display("[TB] FAIL prerst_m16 got %b want 1", out_m16); end
        s_rst = 1'b1; wr_enable = 1'b1;
        tick();
        s_rst = 1'b0; wr_enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            n_checks += 4;
            if (out_l8 !== 1'b0)  begin n_fail++; $display("[TB] FAIL midrst_l8 %0d got %b want 0", j, out_l8); end
            if (out_m8 !== 1'b0)  begin n_fail++; $display("[TB] FAIL midrst_m8 %0d got %b want 0", j, out_m8); end
            if (out_l16 !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_l16 %0d got %b want 0", j, out_l16); end
            if (out_m16 !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_m16 %0d got %b want 0", j, out_m16); end
            tick();
        end
    endtask

    // Back-to-back random words; the model says bit k of the stream is
    // word[k] for LSB-first and word[w-1-k] for MSB-first, and a cycle with
    // enable low repeats the current bit.
    task automatic test_random(input int w, input int n_words);
        logic [15:0] word;
        int k;
        logic obs_l, obs_m, exp_l, exp_m;
        for (int n = 0; n < n_words; n++) begin
            word = 16'($urandom);
            if (w == 8) word[15:8] = 8'h00;
            data8 = word[7:0]; data16 = word;
            enable = 1'b1; wr_enable = 1'b1;
            tick();
            wr_enable = 1'b0;
            k = 0;
            while (1) begin
                obs_l = (w == 8) ? out_l8 : out_l16;
                obs_m = (w == 8) ? out_m8 : out_m16;
                exp_l = word[k];
                exp_m = word[w - 1 - k];
                n_checks += 2;
                if (obs_l !== exp_l) begin n_fail++; $display("[TB] FAIL rand_lsb w%0d word %0d bit %0d got %b want %b", w, n, k, obs_l, exp_l); end
                if (obs_m !== exp_m) begin n_fail++; $display("[TB] FAIL rand_msb w%0d word %0d bit %0d got %b want %b", w, n, k, obs_m, exp_m); end
                if (k == w - 1) break;
                enable = ($urandom_range(0, 7) != 0);
                tick();
                if (enable) k++;
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        s_rst = 1'b1; enable = 1'b0; wr_enable = 1'b0;
        data8 = '0; data16 = '0;
        test_reset();
        test_fixed_word();
        test_enable_stall();
        test_reload_reset();
        test_random(8, 1000);
        test_random(16, 1000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out shift register that converts a `DATA_WIDTH`-bit word into a bit stream, one bit per enabled clock. The shift order is selectable: LSB first or MSB first. It sits at the transmit edge of serial links such as SPI-like, UART-like or LVDS bit lanes, fed by a word-wide producer. It has no flow control; the producer paces loads itself, every `DATA_WIDTH` enabled cycles.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width in bits; minimum 2.
- `DO_MSB_FIRST`, default "FALSE": string. "TRUE" shifts out the MSB first; any other value shifts out the LSB first.

Ports:
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `s_rst_i` in 1: reset, synchronous, active-high.
- `enable_i` in 1: clock enable. When low, all state holds, including loads.
- `wr_enable_i` in 1: parallel load strobe; acts only when `enable_i` is high.
- `data_i` in `DATA_WIDTH`: parallel word, sampled on a load edge.
- `data_o` out 1: serial output bit.

## Operation
- One internal register `shreg[DATA_WIDTH-1:0]`.
- `data_o` is driven combinationally from the register, with no extra flop:
  - LSB-first: `data_o = shreg[0]`.
  - MSB-first: `data_o = shreg[DATA_WIDTH-1]`.
- Per rising edge, in priority order:
  - `s_rst_i`=1: `shreg` <= 0.
  - `enable_i`=0: hold.
  - `wr_enable_i`=1: `shreg` <= `data_i` (load).
  - Otherwise, shift:
    - LSB-first: `shreg` <= {1'b0, `shreg[DATA_WIDTH-1:1]`}.
    - MSB-first: `shreg` <= {`shreg[DATA_WIDTH-2:0]`, 1'b0}.
- Vacated positions fill with 0. After `DATA_WIDTH` shifts without a reload, `data_o` stays 0.
- No word-boundary tracking: a load may occur on any enabled cycle and aborts the word in progress.
- No handshake and no busy/valid outputs.

## Timing
- Reset value: `shreg`=0, so `data_o`=0.
- Latency: on the load edge, `data_o` immediately takes the first bit (bit 0 for LSB-first, bit `DATA_WIDTH-1` for MSB-first).
- Each following enabled edge advances `data_o` to the next bit. Bit k of the sequence is valid during the k-th cycle after the load edge, k = 0..`DATA_WIDTH-1`.
- Back-to-back words: `wr_enable_i` is asserted on the edge after the last bit's cycle. This gives `DATA_WIDTH` cycles per word, with no gap beyond the load cycle itself.
- `enable_i` low for N cycles stretches the current bit by N cycles, with no bit lost.
- Load and shift conditions on the same edge: load wins.
- Reset asserted mid-word: the word is discarded and `data_o` is 0 from the next edge. Reset overrides `wr_enable_i`.
- Reset deasserted: the block idles with output 0 until the first load.

## Structure
- Shared package: the string constants "TRUE"/"FALSE" for `DO_MSB_FIRST`, plus a `DATA_WIDTH >= 2` elaboration check.
- No sub-module: one flat module with one `generate` branch per shift direction.

## Test plan
- Reset: hold `s_rst_i`=1 for 2 cycles with `data_i`=0xFF and `wr_enable_i`=1 -> `data_o`=0, and stays 0 after release with no load.
- LSB-first, 8 bits: load 0xB2 with `enable_i`=1 -> `data_o` = 0,1,0,0,1,1,0,1 on the 8 cycles following the load edge, then 0.
- MSB-first (`DO_MSB_FIRST`="TRUE"): load 0xB2 -> `data_o` = 1,0,1,1,0,0,1,0.
- Enable stall: load 0xB2 LSB-first, then drop `enable_i` for 3 cycles after the 2nd bit -> bit value 1 is held 4 cycles total, and the remaining sequence 0,0,1,1,0,1 is unchanged.
- Mid-word reload and reset: load 0xFF, after 3 bits load 0x00 -> `data_o`=0 from the reload edge. Load 0xFF and assert `s_rst_i` after 2 bits -> `data_o`=0 the next cycle.
- Random regression: 1000 back-to-back random words, both orders, `DATA_WIDTH` 8 and 16 -> zero bit mismatches against the reference bit ordering.
